// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_hazard_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_en_t;

   typedef struct packed {
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_flush_t;

   localparam stage_en_t EN_ALL = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};

endpackage

// File: rtl/hazard_md_counter.sv
// Mult/div busy tracker: loads MD_LAT when a start leaves EX, then counts down to zero.
module hazard_md_counter
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic advance,
   output logic busy
);

   localparam int CW = $clog2(MD_LAT + 1);

   logic [CW-1:0] md_cnt_q, md_cnt_d;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (start && advance) begin
         md_cnt_d = CW'(MD_LAT);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - CW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign busy = (md_cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch, dmem wait and mult/div hazards.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT      = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_md_read,
   input  logic             ex_mem2reg,
   input  logic [REG_W-1:0] ex_writereg,
   input  logic             ex_md_start,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             dmem_ack,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             md_busy,
   output logic             err
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   mem_state_e    state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic          err_q, err_d;
   logic          release_q, release_d;

   logic freeze, timeout, md_struct, md_raw, load_use, ex_advance;
   stage_en_t    en;
   stage_flush_t flush;

   // The cycle after a timeout lets the stuck access leave MEM so the pipe cannot deadlock.
   assign freeze  = mem_req & ~dmem_ack & ~release_q;
   assign timeout = (state_q == WAIT) & ~dmem_ack & (wait_cnt_q == WCW'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      err_d      = err_q;
      release_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (freeze) state_d = WAIT;
         end
         WAIT: begin
            if (dmem_ack) begin
               state_d = IDLE;
            end else if (timeout) begin
               state_d   = IDLE;
               err_d     = 1'b1;
               release_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
         release_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         release_q  <= release_d;
      end
   end

   assign ex_advance = ~freeze & ~md_struct;

   hazard_md_counter #(
      .MD_LAT (MD_LAT)
   ) u_md_counter (
      .clk     (clk),
      .rst     (rst),
      .start   (ex_md_start),
      .advance (ex_advance),
      .busy    (md_busy)
   );

   assign md_struct = ex_md_start & md_busy;
   assign md_raw    = id_md_read & md_busy;
   assign load_use  = ex_mem2reg & (ex_writereg != '0) &
                      ((id_uses_rs & (id_rs == ex_writereg)) |
                       (id_uses_rt & (id_rt == ex_writereg)));

   // A taken branch under a stall still flushes: the held ID instruction is on the wrong path.
   always_comb begin
      en    = EN_ALL;
      flush = '0;
      if (freeze) begin
         en          = '0;
         flush.memwb = 1'b1;
      end else if (md_struct) begin
         en.pc       = 1'b0;
         en.ifid     = 1'b0;
         en.idex     = 1'b0;
         flush.exmem = 1'b1;
      end else begin
         if (md_raw || load_use) begin
            en.pc      = 1'b0;
            en.ifid    = 1'b0;
            flush.idex = 1'b1;
         end
         if (ex_br_taken) begin
            flush.ifid = 1'b1;
            flush.idex = 1'b1;
         end
      end
   end

   assign pc_en       = en.pc;
   assign ifid_en     = en.ifid;
   assign idex_en     = en.idex;
   assign exmem_en    = en.exmem;
   assign memwb_en    = en.memwb;
   assign ifid_flush  = flush.ifid;
   assign idex_flush  = flush.idex;
   assign exmem_flush = flush.exmem;
   assign memwb_flush = flush.memwb;
   assign err         = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_LAT=4 and MEM_TIMEOUT=8.
module tb_pipe_hazard_ctrl;

   localparam int MD_LAT      = 4;
   localparam int MEM_TIMEOUT = 8;

   // Control word order: pc, ifid, idex, exmem, memwb enables, then ifid, idex, exmem, memwb flushes.
   localparam logic [8:0] C_RUN  = 9'b11111_0000;
   localparam logic [8:0] C_FRZ  = 9'b00000_0001;
   localparam logic [8:0] C_LU   = 9'b00111_0100;
   localparam logic [8:0] C_BR   = 9'b11111_1100;
   localparam logic [8:0] C_LUBR = 9'b00111_1100;
   localparam logic [8:0] C_MDS  = 9'b00011_0010;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_writereg;
   logic       id_uses_rs, id_uses_rt, id_md_read, ex_mem2reg, ex_md_start, ex_br_taken;
   logic       mem_req, dmem_ack;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, md_busy, err;

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(
      .MD_LAT      (MD_LAT),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .id_md_read  (id_md_read),
      .ex_mem2reg  (ex_mem2reg),
      .ex_writereg (ex_writereg),
      .ex_md_start (ex_md_start),
      .ex_br_taken (ex_br_taken),
      .mem_req     (mem_req),
      .dmem_ack    (dmem_ack),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .idex_en     (idex_en),
      .exmem_en    (exmem_en),
      .memwb_en    (memwb_en),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exmem_flush (exmem_flush),
      .memwb_flush (memwb_flush),
      .md_busy     (md_busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   wire [10:0] obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, memwb_flush, md_busy, err};

   task automatic idle_inputs();
      id_rs       = '0;
      id_rt       = '0;
      id_uses_rs  = 1'b0;
      id_uses_rt  = 1'b0;
      id_md_read  = 1'b0;
      ex_mem2reg  = 1'b0;
      ex_writereg = '0;
      ex_md_start = 1'b0;
      ex_br_taken = 1'b0;
      mem_req     = 1'b0;
      dmem_ack    = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Samples on the falling edge, mid-cycle, after the inputs of this cycle have settled.
   task automatic chk(input string tag, input logic [8:0] ctl, input logic busy, input logic e);
      logic [10:0] exp;
      exp = {ctl, busy, e};
      @(negedge clk);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      chk("in_reset", C_RUN, 1'b0, 1'b0);
      next_cycle();
      rst = 1'b0;
      chk("idle_after_reset", C_RUN, 1'b0, 1'b0);

      // Load-use on rs: one bubble, then the EX bubble clears the hazard.
      next_cycle();
      ex_mem2reg = 1'b1; ex_writereg = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
      chk("load_use_rs", C_LU, 1'b0, 1'b0);
      next_cycle();
      ex_mem2reg = 1'b0;
      chk("load_use_released", C_RUN, 1'b0, 1'b0);
      next_cycle();
      ex_mem2reg = 1'b1; ex_writereg = 5'd0; id_rs = 5'd0;
      chk("load_use_r0", C_RUN, 1'b0, 1'b0);
      next_cycle();
      idle_inputs();
      ex_mem2reg = 1'b1; ex_writereg = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
      chk("load_use_rt", C_LU, 1'b0, 1'b0);
      next_cycle();
      id_uses_rt = 1'b0;
      chk("load_use_rt_unused", C_RUN, 1'b0, 1'b0);
      next_cycle();
      id_uses_rt = 1'b1; ex_br_taken = 1'b1;
      chk("load_use_and_branch", C_LUBR, 1'b0, 1'b0);
      next_cycle();
      idle_inputs();
      ex_br_taken = 1'b1;
      chk("branch_only", C_BR, 1'b0, 1'b0);

      // Ack three cycles late: three frozen cycles, the ack cycle advances.
      next_cycle();
      idle_inputs();
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mem_wait_%0d", i), C_FRZ, 1'b0, 1'b0);
         next_cycle();
      end
      dmem_ack = 1'b1;
      chk("mem_ack_cycle", C_RUN, 1'b0, 1'b0);
      next_cycle();
      idle_inputs();
      chk("mem_after_ack", C_RUN, 1'b0, 1'b0);

      // Branch held under a freeze flushes in the first unfrozen cycle.
      next_cycle();
      mem_req = 1'b1; ex_br_taken = 1'b1;
      chk("branch_frozen_0", C_FRZ, 1'b0, 1'b0);
      next_cycle();
      chk("branch_frozen_1", C_FRZ, 1'b0, 1'b0);
      next_cycle();
      dmem_ack = 1'b1;
      chk("branch_unfrozen", C_BR, 1'b0, 1'b0);

      // mult then mfhi: four busy cycles stall mfhi, it issues when busy falls.
      next_cycle();
      idle_inputs();
      ex_md_start = 1'b1;
      chk("md_start", C_RUN, 1'b0, 1'b0);
      next_cycle();
      ex_md_start = 1'b0; id_md_read = 1'b1;
      for (int i = 0; i < MD_LAT; i++) begin
         chk($sformatf("mfhi_stall_%0d", i), C_LU, 1'b1, 1'b0);
         next_cycle();
      end
      chk("mfhi_issue", C_RUN, 1'b0, 1'b0);

      // Back-to-back mult: the second one holds EX until busy falls.
      next_cycle();
      idle_inputs();
      ex_md_start = 1'b1;
      chk("md_first", C_RUN, 1'b0, 1'b0);
      for (int i = 0; i < MD_LAT; i++) begin
         next_cycle();
         chk($sformatf("md_struct_%0d", i), C_MDS, 1'b1, 1'b0);
      end
      next_cycle();
      chk("md_second_advances", C_RUN, 1'b0, 1'b0);
      next_cycle();
      ex_md_start = 1'b0;
      chk("md_second_busy", C_RUN, 1'b1, 1'b0);
      rst = 1'b1;
      chk("rst_aborts_md", C_RUN, 1'b0, 1'b0);
      next_cycle();
      rst = 1'b0;

      // Timeout: 8 WAIT cycles, err sets, one released cycle, then refreeze.
      mem_req = 1'b1;
      chk("to_idle_cycle", C_FRZ, 1'b0, 1'b0);
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         next_cycle();
         chk($sformatf("to_wait_%0d", i), C_FRZ, 1'b0, 1'b0);
      end
      next_cycle();
      chk("to_release", C_RUN, 1'b0, 1'b1);
      next_cycle();
      chk("to_refreeze", C_FRZ, 1'b0, 1'b1);
      next_cycle();
      mem_req = 1'b0;
      chk("err_sticky_0", C_RUN, 1'b0, 1'b1);
      next_cycle();
      chk("err_sticky_1", C_RUN, 1'b0, 1'b1);
      rst = 1'b1;
      chk("rst_clears_err", C_RUN, 1'b0, 1'b0);
      next_cycle();
      rst = 1'b0;
      chk("idle_after_final_reset", C_RUN, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall and flush controller for the 5-stage MIPS pipeline. Generates per-stage enable and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Handles load-use hazards, taken-branch flushes, data-memory wait states (req/ack handshake with timeout) and a multi-cycle multiply/divide unit. Sits beside the datapath; every pipeline stage register takes its enable and flush from this block.

## Interface
- MD_LAT, 32: mult/div busy cycles after start, at least 1.
- MEM_TIMEOUT, 255: maximum wait cycles for dmem_ack before err is set.
- clk  in  1  clock; all stage registers sample on posedge.
- rst  in  1  asynchronous reset, active-high.
- id_rs, id_rt  in  5 each  source register numbers in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- id_md_read  in  1  ID instruction is mfhi/mflo.
- ex_mem2reg  in  1  EX instruction is a load.
- ex_writereg  in  5  EX destination register.
- ex_md_start  in  1  EX instruction starts a mult/div.
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM instruction accesses data memory.
- dmem_ack  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enable.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  stage register loads all-zero (bubble) at next edge; flush overrides en.
- md_busy  out  1  mult/div unit is computing.
- err  out  1  sticky memory timeout flag.

## Operation
- Memory FSM with states IDLE and WAIT.
  - IDLE: if mem_req=1 and dmem_ack=0, go to WAIT.
  - WAIT: if dmem_ack=1, go to IDLE.
  - freeze = mem_req & ~dmem_ack, in either state.
- Wait counter: cleared in IDLE and increments in WAIT. When it reaches MEM_TIMEOUT, set err (sticky until rst) and force the FSM to IDLE, which releases the freeze for one cycle.
- Mult/div counter md_cnt (width clog2(MD_LAT+1)). Loads MD_LAT when ex_md_start=1 and EX advances, then decrements to 0. md_busy = (md_cnt != 0).
- Hazard terms:
  - md_struct = ex_md_start & md_busy.
  - md_raw = id_md_read & md_busy.
  - load_use = ex_mem2reg & (ex_writereg != 0) & ((id_uses_rs & id_rs == ex_writereg) | (id_uses_rt & id_rt == ex_writereg)).
- Priority, highest first:
  1. freeze: all en = 0, memwb_flush = 1, all other flushes = 0.
  2. md_struct: pc/ifid/idex en = 0, exmem_flush = 1.
  3. md_raw or load_use: pc/ifid en = 0, idex_flush = 1.
  4. ex_br_taken: ifid_flush = 1, idex_flush = 1.
  5. Otherwise all en = 1 and all flushes = 0.
- A branch seen under a higher-priority condition is not lost. EX holds, so ex_br_taken stays asserted until EX advances.
- Rule 4 can coexist with rule 3. Both set idex_flush, and ifid_flush also applies because the stalled ID instruction lies on the wrong path.
- All outputs are combinational from state and inputs. No output is registered.

## Timing
- Reset values: FSM = IDLE, wait counter = 0, md_cnt = 0, md_busy = 0, err = 0. With idle inputs, all en = 1 and all flushes = 0.
- Reset asserted mid-operation aborts WAIT and any mult/div count immediately.
- Load-use costs 1 bubble.
- Memory wait costs N stall cycles for an ack N cycles late. The ack cycle itself advances.
- md_busy is high for exactly MD_LAT cycles after the start edge.
- mfhi/mflo stalls until the cycle md_busy falls, and issues in that cycle.
- MD_LAT=1: busy for one cycle only.
- Register $0 never triggers load_use.

## Structure
- Shared package holds:
  - stage-enable bundle typedef;
  - memory FSM state enum {IDLE, WAIT};
  - REG_W=5 constant.
- One sub-module, hazard_md_counter, implements md_cnt and md_busy. Parameter MD_LAT; inputs start, advance.

## Test plan
- Load to r5 in EX, ID reads rs=5 -> exactly one cycle with pc_en=ifid_en=0 and idex_flush=1, then all en=1. Same stimulus with ex_writereg=0 -> no stall.
- mem_req=1 with dmem_ack after 3 cycles -> memwb_flush=1 and all en=0 for 3 cycles; the ack cycle has all en=1.
- ex_md_start with MD_LAT=4, then mfhi in ID -> md_busy high for 4 cycles, stall held, mfhi advances in the cycle md_busy falls.
- ex_br_taken=1 during a freeze -> no flush while frozen; ifid_flush=idex_flush=1 in the first unfrozen cycle.
- mem_req held with no ack, MEM_TIMEOUT=8 -> err=1 after 8 WAIT cycles, stays 1 until rst; rst returns every output to its reset value.
- Second ex_md_start while md_busy=1 -> exmem_flush=1 and pc/ifid/idex en=0 until md_busy falls.
